// File: rtl/sysid_ctrl_pkg.sv
// Shared types for the system-ID access controller: FSM state encoding and slave word addresses.
package sysid_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ID       = 3'd1,
        S_TS       = 3'd2,
        S_EVAL     = 3'd3,
        S_HOST     = 3'd4,
        S_HOST_RSP = 3'd5
    } state_e;

    localparam logic SID_ADDR_ID = 1'b0;
    localparam logic SID_ADDR_TS = 1'b1;

endpackage

// File: rtl/sysid_recheck_timer.sv
// Free-running recheck counter: raises expire_o on its last count and wraps; a period of 0 disables it.
module sysid_recheck_timer #(
    parameter int CNT_W          = 32,
    parameter int RECHECK_PERIOD = 0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic reload_i,
    output logic expire_o
);

    localparam bit              EN   = (RECHECK_PERIOD != 0);
    localparam logic [CNT_W-1:0] LAST = EN ? CNT_W'(RECHECK_PERIOD - 1) : '0;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!EN || reload_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = EN && (cnt_q == LAST);

endmodule

// File: rtl/sysid_access_ctrl.sv
// Arbitrates the sysid slave between a periodic ID/timestamp self-check and one host read port;
// the self-check wins ties, but a waiting host is served right after the check that beat it.
module sysid_access_ctrl
    import sysid_ctrl_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = 32'h0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1537626416,
    parameter int          RECHECK_PERIOD = 0,
    parameter int          CNT_W          = 32
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        host_read,
    input  logic        host_address,
    output logic [31:0] host_readdata,
    output logic        host_waitrequest,
    output logic        sid_address,
    input  logic [31:0] sid_readdata,
    output logic        check_done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        mismatch_pulse,
    output state_e      dbg_state_o
);

    state_e      state_q;
    logic        chk_pend_q;
    logic        chk_pend_d;
    logic        host_turn_q;
    logic        sid_addr_q;
    logic [31:0] rdata_q;
    logic [31:0] host_rdata_q;
    logic        id_match_q;
    logic        check_done_q;
    logic        id_ok_q;
    logic        ts_ok_q;
    logic        mismatch_q;

    logic        expire;
    logic        pend_now;
    logic        take_check;
    logic        ts_match;

    sysid_recheck_timer #(
        .CNT_W          (CNT_W),
        .RECHECK_PERIOD (RECHECK_PERIOD)
    ) u_timer (
        .clock    (clock),
        .reset_n  (reset_n),
        .reload_i (take_check),
        .expire_o (expire)
    );

    // A pending check is consumed the same cycle it launches, so start/expiry arriving
    // while idle merge into that check instead of queueing a second one.
    assign pend_now   = chk_pend_q || start || expire;
    assign take_check = (state_q == S_IDLE) && pend_now && !(host_turn_q && host_read);
    assign chk_pend_d = take_check ? 1'b0 : pend_now;
    assign ts_match   = (rdata_q == EXPECTED_TS);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            chk_pend_q   <= 1'b1;
            host_turn_q  <= 1'b0;
            sid_addr_q   <= SID_ADDR_ID;
            rdata_q      <= '0;
            host_rdata_q <= '0;
            id_match_q   <= 1'b0;
            check_done_q <= 1'b0;
            id_ok_q      <= 1'b0;
            ts_ok_q      <= 1'b0;
            mismatch_q   <= 1'b0;
        end else begin
            chk_pend_q <= chk_pend_d;
            mismatch_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (take_check) begin
                        state_q     <= S_ID;
                        sid_addr_q  <= SID_ADDR_ID;
                        host_turn_q <= 1'b0;
                    end else if (host_read) begin
                        state_q     <= S_HOST;
                        sid_addr_q  <= host_address;
                        host_turn_q <= 1'b0;
                    end
                end
                S_ID: begin
                    rdata_q    <= sid_readdata;
                    sid_addr_q <= SID_ADDR_TS;
                    state_q    <= S_TS;
                end
                S_TS: begin
                    id_match_q <= (rdata_q == EXPECTED_ID);
                    rdata_q    <= sid_readdata;
                    state_q    <= S_EVAL;
                end
                S_EVAL: begin
                    id_ok_q      <= id_match_q;
                    ts_ok_q      <= ts_match;
                    check_done_q <= 1'b1;
                    mismatch_q   <= !(id_match_q && ts_match);
                    host_turn_q  <= 1'b1;
                    state_q      <= S_IDLE;
                end
                S_HOST: begin
                    rdata_q <= sid_readdata;
                    // A host that dropped its request mid-access gets nothing back.
                    if (host_read) begin
                        host_rdata_q <= sid_readdata;
                    end
                    state_q <= S_HOST_RSP;
                end
                S_HOST_RSP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign host_waitrequest = host_read && (state_q != S_HOST_RSP);
    assign host_readdata    = host_rdata_q;
    assign sid_address      = sid_addr_q;
    assign check_done       = check_done_q;
    assign id_ok            = id_ok_q;
    assign ts_ok            = ts_ok_q;
    assign mismatch_pulse   = mismatch_q;
    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_sysid_access_ctrl.sv
// Directed bench for sysid_access_ctrl: default, wrong-timestamp and periodic-recheck instances.
module tb_sysid_access_ctrl;
    import sysid_ctrl_pkg::*;

    localparam logic [31:0] TS_DEF = 32'h5BA65130;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    // instance A: defaults
    logic        a_start, a_host_read, a_host_address, a_waitreq, a_sid_addr;
    logic        a_done, a_id_ok, a_ts_ok, a_mis;
    logic [31:0] a_host_rdata, a_sid_rdata, a_id, a_ts;
    state_e      a_state;
    // instance B: expected timestamp off by one
    logic        b_start, b_host_read, b_host_address, b_waitreq, b_sid_addr;
    logic        b_done, b_id_ok, b_ts_ok, b_mis;
    logic [31:0] b_host_rdata, b_sid_rdata;
    state_e      b_state;
    // instance C: recheck every 10 cycles
    logic        c_start, c_host_read, c_host_address, c_waitreq, c_sid_addr;
    logic        c_done, c_id_ok, c_ts_ok, c_mis;
    logic [31:0] c_host_rdata, c_sid_rdata, c_ts;
    state_e      c_state;

    assign a_sid_rdata = a_sid_addr ? a_ts : a_id;
    assign b_sid_rdata = b_sid_addr ? TS_DEF : 32'h0;
    assign c_sid_rdata = c_sid_addr ? c_ts : 32'h0;

    sysid_access_ctrl dut_a (
        .clock(clock), .reset_n(reset_n), .start(a_start), .host_read(a_host_read),
        .host_address(a_host_address), .host_readdata(a_host_rdata), .host_waitrequest(a_waitreq),
        .sid_address(a_sid_addr), .sid_readdata(a_sid_rdata), .check_done(a_done),
        .id_ok(a_id_ok), .ts_ok(a_ts_ok), .mismatch_pulse(a_mis), .dbg_state_o(a_state)
    );

    sysid_access_ctrl #(.EXPECTED_TS(32'h5BA65131)) dut_b (
        .clock(clock), .reset_n(reset_n), .start(b_start), .host_read(b_host_read),
        .host_address(b_host_address), .host_readdata(b_host_rdata), .host_waitrequest(b_waitreq),
        .sid_address(b_sid_addr), .sid_readdata(b_sid_rdata), .check_done(b_done),
        .id_ok(b_id_ok), .ts_ok(b_ts_ok), .mismatch_pulse(b_mis), .dbg_state_o(b_state)
    );

    sysid_access_ctrl #(.RECHECK_PERIOD(10)) dut_c (
        .clock(clock), .reset_n(reset_n), .start(c_start), .host_read(c_host_read),
        .host_address(c_host_address), .host_readdata(c_host_rdata), .host_waitrequest(c_waitreq),
        .sid_address(c_sid_addr), .sid_readdata(c_sid_rdata), .check_done(c_done),
        .id_ok(c_id_ok), .ts_ok(c_ts_ok), .mismatch_pulse(c_mis), .dbg_state_o(c_state)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Host read on A: counts waitrequest-high cycles, then checks data against the queue head.
    task automatic host_read_a(input logic addr, input logic with_start, input int exp_wait);
        int waits;
        logic [31:0] exp;
        waits = 0;
        a_host_read = 1'b1;
        a_host_address = addr;
        a_start = with_start;
        forever begin
            #1;
            if (!a_waitreq || waits >= 20) break;
            waits++;
            tick();
            a_start = 1'b0;
        end
        exp = exp_q.pop_front();
        check_eq("host_wait_cycles", 32'(waits), 32'(exp_wait));
        check_eq("host_readdata", a_host_rdata, exp);
        a_host_read = 1'b0;
        a_start = 1'b0;
        tick();
    endtask

    initial begin
        int waits;
        int cnt;
        int mis_cnt;
        reset_n = 1'b0;
        {a_start, a_host_read, a_host_address} = '0;
        {b_start, b_host_read, b_host_address} = '0;
        {c_start, c_host_read, c_host_address} = '0;
        a_id = 32'h0;
        a_ts = TS_DEF;
        c_ts = TS_DEF;
        tick(2);

        // reset values
        check_eq("rst_state", 32'(a_state), 32'(S_IDLE));
        check_eq("rst_check_done", 32'(a_done), 32'd0);
        check_eq("rst_id_ok", 32'(a_id_ok), 32'd0);
        check_eq("rst_ts_ok", 32'(a_ts_ok), 32'd0);
        check_eq("rst_mismatch", 32'(a_mis), 32'd0);
        check_eq("rst_sid_address", 32'(a_sid_addr), 32'd0);
        check_eq("rst_host_readdata", a_host_rdata, 32'd0);

        // first check after reset release
        reset_n = 1'b1;
        tick();
        check_eq("post_rst_edge1_state", 32'(a_state), 32'(S_ID));
        tick();
        check_eq("post_rst_edge2_state", 32'(a_state), 32'(S_TS));
        check_eq("post_rst_edge2_sid_addr", 32'(a_sid_addr), 32'd1);
        tick();
        check_eq("post_rst_edge3_state", 32'(a_state), 32'(S_EVAL));
        check_eq("post_rst_edge3_done_held", 32'(a_done), 32'd0);
        tick();
        check_eq("a_check_done", 32'(a_done), 32'd1);
        check_eq("a_id_ok", 32'(a_id_ok), 32'd1);
        check_eq("a_ts_ok", 32'(a_ts_ok), 32'd1);
        check_eq("a_no_mismatch", 32'(a_mis), 32'd0);
        check_eq("b_ts_ok", 32'(b_ts_ok), 32'd0);
        check_eq("b_id_ok", 32'(b_id_ok), 32'd1);
        check_eq("b_mismatch_pulse", 32'(b_mis), 32'd1);
        tick();
        check_eq("b_mismatch_one_cycle", 32'(b_mis), 32'd0);

        // B re-check on start
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        tick(2);
        check_eq("b_recheck_flags_held_ts", 32'(b_ts_ok), 32'd0);
        check_eq("b_recheck_flags_held_id", 32'(b_id_ok), 32'd1);
        tick();
        check_eq("b_recheck_mismatch", 32'(b_mis), 32'd1);
        check_eq("b_recheck_ts_ok", 32'(b_ts_ok), 32'd0);
        tick();
        check_eq("b_recheck_mismatch_end", 32'(b_mis), 32'd0);

        // host reads
        exp_q.push_back(TS_DEF);
        host_read_a(1'b1, 1'b0, 2);
        exp_q.push_back(32'h0);
        host_read_a(1'b0, 1'b0, 2);

        // host and start together: check first
        exp_q.push_back(TS_DEF);
        host_read_a(1'b1, 1'b1, 6);
        check_eq("a_flags_after_contention", 32'({a_done, a_id_ok, a_ts_ok}), 32'd7);

        // starts during a check merge into one extra check
        a_start = 1'b1;
        tick();
        check_eq("merge_first_state", 32'(a_state), 32'(S_ID));
        tick();
        tick();
        a_start = 1'b0;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (a_state == S_ID) cnt++;
        end
        check_eq("merged_extra_checks", 32'(cnt), 32'd1);

        // C: periodic recheck catches a runtime timestamp change
        check_eq("c_ts_ok_initial", 32'(c_ts_ok), 32'd1);
        c_ts = 32'h12345678;
        waits = 0;
        while (c_ts_ok && waits < 30) begin
            tick();
            waits++;
        end
        check_eq("c_ts_fall_within_bound", 32'(waits <= 14), 32'd1);
        check_eq("c_id_ok_kept", 32'(c_id_ok), 32'd1);
        cnt = 0;
        mis_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (c_state == S_ID) cnt++;
            if (c_mis) mis_cnt++;
        end
        check_eq("c_period_checks", 32'(cnt), 32'd3);
        check_eq("c_period_mismatches", 32'(mis_cnt), 32'd3);
        c_ts = TS_DEF;
        tick(14);
        check_eq("c_ts_ok_restored", 32'(c_ts_ok), 32'd1);

        // reset in S_TS
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        tick();
        check_eq("pre_reset_state", 32'(a_state), 32'(S_TS));
        reset_n = 1'b0;
        #1;
        check_eq("midrst_state", 32'(a_state), 32'(S_IDLE));
        check_eq("midrst_flags", 32'({a_done, a_id_ok, a_ts_ok, a_mis}), 32'd0);
        check_eq("midrst_sid_addr", 32'(a_sid_addr), 32'd0);
        check_eq("midrst_host_readdata", a_host_rdata, 32'd0);
        tick();
        reset_n = 1'b1;
        tick(4);
        check_eq("rerun_a_flags", 32'({a_done, a_id_ok, a_ts_ok}), 32'd7);
        check_eq("rerun_b_mismatch", 32'(b_mis), 32'd1);
        check_eq("rerun_b_flags", 32'({b_done, b_id_ok, b_ts_ok}), 32'd6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
